mem_burst_ctrl: RTL
===================

Name: mem_burst_ctrl

Overview:
- Memory-side stage that sits directly downstream of a d_cache instance.
- Consumes the cache's miss/writeback request: valid, read/write_n, 2-byte-aligned address, write data.
- Drives the cache's memory-return inputs: valid, data-read strobe, last, data.
- Converts each request into a fixed-length line burst on a synchronous SRAM-style backend with fixed read latency.

Parameters:
- DATA_WIDTH, 32, word width of the cache and backend.
- ADDRESS_WIDTH, 22, request address width in bits, 2-byte aligned; bit 0 is ignored.
- BLOCK_OFFSET_WIDTH, 2, log2 of words per line; BURST_LEN = 2**BLOCK_OFFSET_WIDTH.
- READ_LATENCY, 2, backend cycles from read issue to i_SRAM_Rdata valid; legal range 1..4.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Valid  in  1  cache request valid (o_MEM_Valid of the cache).
- i_Read_Write_n  in  1  1 = line fill, 0 = line writeback.
- i_Address  in  ADDRESS_WIDTH  request address, 2-byte aligned.
- i_Data  in  DATA_WIDTH  writeback word currently presented by the cache.
- o_Valid  out  1  read word valid (drives the cache's i_MEM_Valid).
- o_Data_Read  out  1  writeback word consumed this cycle (drives i_MEM_Data_Read).
- o_Last  out  1  final word of the burst (drives i_MEM_Last).
- o_Data  out  DATA_WIDTH  read word (drives i_MEM_Data).
- o_Busy  out  1  high in any state other than IDLE.
- o_SRAM_Addr  out  ADDRESS_WIDTH-1  backend word address.
- o_SRAM_En  out  1  backend access enable.
- o_SRAM_We  out  1  backend write enable.
- o_SRAM_Wdata  out  DATA_WIDTH  backend write data.
- i_SRAM_Rdata  in  DATA_WIDTH  backend read data, READ_LATENCY cycles after an enabled read.

Behaviour:
- Reset (async, i_Reset=1): state=IDLE; all outputs 0; offset counter, issue counter and read-valid pipeline cleared.
- Reset mid-burst: in-flight reads are dropped; no o_Valid or o_Last is produced after reset deasserts.
- Word address: waddr = i_Address[ADDRESS_WIDTH-1:1]. The line base is waddr with the low BLOCK_OFFSET_WIDTH bits cleared.
- Beat k is at base | ((start+k) mod BURST_LEN). start = 0 unless the optional feature is compiled in. The offset wraps within the line and never carries into the tag/index bits.
- FSM states: IDLE, RD_ISSUE, RD_DRAIN, WR, DONE.
- IDLE:
  - i_Valid=1 latches base, offset and direction.
  - Next state is RD_ISSUE if i_Read_Write_n=1, else WR.
  - Request acceptance adds no cycle beyond this latch.
- RD_ISSUE:
  - Issues one read per cycle: o_SRAM_En=1, o_SRAM_We=0, beats 0..BURST_LEN-1.
  - After the last issue, moves to RD_DRAIN.
- Read return path:
  - A READ_LATENCY-deep valid pipeline tags each issued beat.
  - When a tagged beat emerges, o_Valid=1 and o_Data=i_SRAM_Rdata, registered, so it appears one cycle after the backend data.
  - The first o_Valid occurs READ_LATENCY+1 cycles after the first issue.
  - Returned beats are contiguous, exactly BURST_LEN of them.
  - o_Last=1 together with o_Valid on beat BURST_LEN-1 only.
- RD_DRAIN: waits until the last beat's o_Valid/o_Last is driven, then moves to DONE.
- WR:
  - Each cycle: o_SRAM_En=1, o_SRAM_We=1, o_SRAM_Wdata=i_Data, o_Data_Read=1.
  - The cache must present the next word on the cycle after a word is consumed.
  - o_Last=1 with o_Data_Read on beat BURST_LEN-1, then moves to DONE.
- DONE:
  - Outputs idle; i_Valid is not sampled as a new request.
  - Returns to IDLE on the first cycle i_Valid=0. This prevents a stale valid from retriggering the same burst.
- Simultaneous events:
  - i_Valid toggling or i_Address changing mid-burst is ignored; latched values are used.
  - i_Read_Write_n is sampled only in IDLE.
- o_Valid and o_Data_Read are never high in the same cycle.
- o_Data holds its last value when o_Valid=0.

Optional Feature:
- Macro MEM_BURST_CRIT_WORD_FIRST_EN.
- Defined: start = waddr[BLOCK_OFFSET_WIDTH-1:0] for reads and writes. The requested word returns first and later beats wrap modulo BURST_LEN.
- Undefined: start = 0 and every burst runs offset 0..BURST_LEN-1 regardless of the request offset.

Decomposition:
- Package mem_burst_pkg contains:
  - state enum typedef (IDLE, RD_ISSUE, RD_DRAIN, WR, DONE);
  - localparam-style function burst_len(BLOCK_OFFSET_WIDTH);
  - offset typedef sized by BLOCK_OFFSET_WIDTH.
- Sub-module mem_rd_pipe: READ_LATENCY-deep shift register carrying {valid, last} per issued beat, asynchronously cleared.

Test Plan:
- Read fill, i_Address=22'h000124 (waddr 0x92, base 0x90), READ_LATENCY=2, backend preloaded 0x90..0x93 = A0..A3 -> o_SRAM_Addr 0x90,0x91,0x92,0x93 on consecutive cycles; o_Valid for 4 contiguous cycles with data A0..A3; first o_Valid 3 cycles after the first issue; o_Last on A3 only.
- Writeback to i_Address=22'h000200, cache supplies D0..D3 -> 4 consecutive o_SRAM_We pulses at 0x100..0x103 with D0..D3; o_Data_Read high for 4 cycles; o_Last on the 4th.
- Hold i_Valid=1 for 3 cycles after o_Last -> FSM stays in DONE with no new o_SRAM_En; returns to IDLE the cycle after i_Valid falls.
- Assert i_Reset for 1 cycle after the 2nd read issue -> all outputs 0 immediately; no o_Valid in the following 10 cycles; a new request then completes normally.
- With MEM_BURST_CRIT_WORD_FIRST_EN, read i_Address=22'h000124 -> addresses 0x92,0x93,0x90,0x91; o_Last on the 0x91 data.
- READ_LATENCY=4, back-to-back read then write requests -> no beat lost; o_Valid and o_Data_Read never overlap.

Source files
------------

// File: rtl/mem_burst_pkg.sv
// Shared types and helpers for the memory burst controller (mem_burst_ctrl).
package mem_burst_pkg;

    localparam int DEF_BLOCK_OFFSET_WIDTH = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DRAIN,
        WR,
        DONE
    } state_t;

    typedef logic [DEF_BLOCK_OFFSET_WIDTH-1:0] offset_t;

    function automatic int burst_len(input int offset_width);
        return 1 << offset_width;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return tag pipeline: carries {valid, last} for each issued read beat so
// it emerges in the same cycle the backend presents that beat's data.
module mem_rd_pipe #(
    parameter int DEPTH = 2
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Valid,
    input  logic i_Last,
    output logic o_Valid,
    output logic o_Last
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] last_q;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            valid_q[0] <= i_Valid;
            last_q[0]  <= i_Valid & i_Last;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                last_q[i]  <= last_q[i-1];
            end
        end
    end

    assign o_Valid = valid_q[DEPTH-1];
    assign o_Last  = last_q[DEPTH-1];

endmodule

// File: rtl/mem_burst_ctrl.sv
// Turns d_cache line fill / writeback requests into fixed-length SRAM bursts.
// Define MEM_BURST_CRIT_WORD_FIRST_EN to start each burst at the requested word.
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDRESS_WIDTH      = 22,
    parameter int BLOCK_OFFSET_WIDTH = DEF_BLOCK_OFFSET_WIDTH,
    parameter int READ_LATENCY       = 2
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Valid,
    input  logic                     i_Read_Write_n,
    input  logic [ADDRESS_WIDTH-1:0] i_Address,
    input  logic [DATA_WIDTH-1:0]    i_Data,
    output logic                     o_Valid,
    output logic                     o_Data_Read,
    output logic                     o_Last,
    output logic [DATA_WIDTH-1:0]    o_Data,
    output logic                     o_Busy,
    output logic [ADDRESS_WIDTH-2:0] o_SRAM_Addr,
    output logic                     o_SRAM_En,
    output logic                     o_SRAM_We,
    output logic [DATA_WIDTH-1:0]    o_SRAM_Wdata,
    input  logic [DATA_WIDTH-1:0]    i_SRAM_Rdata,
    output logic [2:0]               o_State
);

    localparam int TAG_W     = ADDRESS_WIDTH - 1 - BLOCK_OFFSET_WIDTH;
    localparam int BURST_LEN = burst_len(BLOCK_OFFSET_WIDTH);
    localparam logic [BLOCK_OFFSET_WIDTH-1:0] LAST_BEAT = BLOCK_OFFSET_WIDTH'(BURST_LEN - 1);
    localparam logic [BLOCK_OFFSET_WIDTH-1:0] ONE_BEAT  = BLOCK_OFFSET_WIDTH'(1);

    state_t                        state_q;
    logic [TAG_W-1:0]              tag_q;
    logic [BLOCK_OFFSET_WIDTH-1:0] off_q;
    logic [BLOCK_OFFSET_WIDTH-1:0] cnt_q;
    logic [BLOCK_OFFSET_WIDTH-1:0] next_off;
    logic [BLOCK_OFFSET_WIDTH-1:0] next_cnt;
    logic [BLOCK_OFFSET_WIDTH-1:0] start_off;
    logic [TAG_W-1:0]              req_tag;
    logic                          issue_last;
    logic                          pipe_valid;
    logic                          pipe_last;
    logic                          unused_addr_bits;

    assign req_tag = i_Address[ADDRESS_WIDTH-1:BLOCK_OFFSET_WIDTH+1];

`ifdef MEM_BURST_CRIT_WORD_FIRST_EN
    assign start_off        = i_Address[BLOCK_OFFSET_WIDTH:1];
    assign unused_addr_bits = i_Address[0];
`else
    assign start_off        = '0;
    assign unused_addr_bits = ^i_Address[BLOCK_OFFSET_WIDTH:0];
`endif

    // Offset arithmetic is confined to the low bits so a burst wraps inside its line.
    assign next_off   = off_q + ONE_BEAT;
    assign next_cnt   = cnt_q + ONE_BEAT;
    assign issue_last = (state_q == RD_ISSUE) && (cnt_q == LAST_BEAT);

    mem_rd_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_rd_pipe (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Valid (o_SRAM_En & ~o_SRAM_We),
        .i_Last  (issue_last),
        .o_Valid (pipe_valid),
        .o_Last  (pipe_last)
    );

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            o_Valid     <= 1'b0;
            o_Data_Read <= 1'b0;
            o_Last      <= 1'b0;
            o_Data      <= '0;
            o_SRAM_Addr <= '0;
            o_SRAM_En   <= 1'b0;
            o_SRAM_We   <= 1'b0;
        end else begin
            // Read return runs independently of the FSM, one cycle behind the backend.
            o_Valid <= pipe_valid;
            o_Last  <= pipe_valid & pipe_last;
            if (pipe_valid) begin
                o_Data <= i_SRAM_Rdata;
            end

            case (state_q)
                IDLE: begin
                    if (i_Valid) begin
                        tag_q       <= req_tag;
                        off_q       <= start_off;
                        cnt_q       <= '0;
                        o_SRAM_En   <= 1'b1;
                        o_SRAM_Addr <= {req_tag, start_off};
                        if (i_Read_Write_n) begin
                            o_SRAM_We <= 1'b0;
                            state_q   <= RD_ISSUE;
                        end else begin
                            o_SRAM_We   <= 1'b1;
                            o_Data_Read <= 1'b1;
                            state_q     <= WR;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (cnt_q == LAST_BEAT) begin
                        o_SRAM_En   <= 1'b0;
                        o_SRAM_Addr <= '0;
                        state_q     <= RD_DRAIN;
                    end else begin
                        cnt_q       <= next_cnt;
                        off_q       <= next_off;
                        o_SRAM_Addr <= {tag_q, next_off};
                    end
                end
                RD_DRAIN: begin
                    if (pipe_valid && pipe_last) begin
                        state_q <= DONE;
                    end
                end
                WR: begin
                    if (cnt_q == LAST_BEAT) begin
                        o_SRAM_En   <= 1'b0;
                        o_SRAM_We   <= 1'b0;
                        o_Data_Read <= 1'b0;
                        o_SRAM_Addr <= '0;
                        o_Last      <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        cnt_q       <= next_cnt;
                        off_q       <= next_off;
                        o_SRAM_Addr <= {tag_q, next_off};
                        o_Last      <= (next_cnt == LAST_BEAT);
                    end
                end
                DONE: begin
                    // Wait for the cache to drop valid so a stale request is not replayed.
                    if (!i_Valid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write data passes straight through so the cache can advance one word per cycle.
    assign o_SRAM_Wdata = o_SRAM_We ? i_Data : '0;
    assign o_Busy       = (state_q != IDLE);
    assign o_State      = state_q;

endmodule
